// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//   Shares one physical-memory port between an I-cache (line fills only) and a
//   D-cache (line fills and writebacks). One transaction is in flight at a
//   time. When both caches request in the same cycle, the cache that was not
//   granted most recently wins.
//
//   Handshake: a cache raises read/write and holds it until it sees its resp
//   pulse. The arbiter raises a pmem strobe the cycle after the grant and holds
//   it until pmem_resp. resp to the cache is combinational with pmem_resp and
//   lasts one cycle. A RECOVER cycle follows, so the cache can drop its request
//   before the next arbitration.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   icache_read           I-cache fill request
//   icache_address        I-cache line address
//   icache_rdata/resp     I-cache fill data / completion pulse
//   dcache_read/write     D-cache fill / writeback request (both high = write)
//   dcache_address/wdata  D-cache line address / writeback data
//   dcache_rdata/resp     D-cache fill data / completion pulse
//   pmem_read/write       memory strobes, held until pmem_resp
//   pmem_address/wdata    memory address / write data (from latched copies)
//   pmem_rdata/resp       memory read data / completion
//   fsm_state             current state (0 IDLE, 1 SERVE_I, 2 SERVE_D, 3 RECOVER)
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic              last_grant_d;  // 1: D-cache was granted most recently
    logic              op_write;      // latched operation of the D transaction
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state)
            IDLE: begin
                // On a conflict D wins unless it was the last one granted.
                if (d_req && (!i_req || !last_grant_d)) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    icache_resp = 1'b1;
                    state_next  = RECOVER;
                end
            end
            SERVE_D: begin
                pmem_read  = ~op_write;
                pmem_write = op_write;
                if (pmem_resp) begin
                    dcache_resp = 1'b1;
                    state_next  = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (grant_d) begin
                addr_q       <= dcache_address;
                wdata_q      <= dcache_wdata;
                op_write     <= dcache_write;  // read+write together counts as write
                last_grant_d <= 1'b1;
            end else if (grant_i) begin
                addr_q       <= icache_address;
                op_write     <= 1'b0;
                last_grant_d <= 1'b0;
            end
            if (icache_resp || dcache_resp) begin
                rdata_q <= pmem_rdata;
            end
        end
    end

    // Fill data passes straight through on the response cycle, then the
    // captured copy is held until the next completion.
    assign icache_rdata = icache_resp ? pmem_rdata : rdata_q;
    assign dcache_rdata = dcache_resp ? pmem_rdata : rdata_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (who owns memory, whether a recovery cycle is pending, who was
//   granted last, the latched request) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [1:0]        fsm_state;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .fsm_state      (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int vectors;
    int miscompares;

    // Reference model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
    int                m_owner;
    bit                m_recov;
    bit                m_last_d;
    bit                m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;

    logic [LINE_W-1:0] a5_line;
    logic [LINE_W-1:0] tmp_line;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_recov  = 1'b0;
        m_last_d = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdata  = '0;
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic sample();
        logic e_pr, e_pw, e_ir, e_dr;
        @(negedge clk);
        e_pr = (m_owner == 1) || (m_owner == 2 && !m_wr);
        e_pw = (m_owner == 2) && m_wr;
        e_ir = (m_owner == 1) && pmem_resp;
        e_dr = (m_owner == 2) && pmem_resp;
        check_bit("pmem_read", pmem_read, e_pr);
        check_bit("pmem_write", pmem_write, e_pw);
        check_bit("icache_resp", icache_resp, e_ir);
        check_bit("dcache_resp", dcache_resp, e_dr);
        check_vec("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
        check_vec("pmem_wdata", pmem_wdata, m_wdata);
        check_vec("icache_rdata", icache_rdata, e_ir ? pmem_rdata : m_rdata);
        check_vec("dcache_rdata", dcache_rdata, e_dr ? pmem_rdata : m_rdata);
    endtask

    // Clock edge: update the model from the inputs the DUT just sampled.
    task automatic advance();
        bit want_i, want_d, take_d;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_rdata = pmem_rdata;
                m_owner = 0;
                m_recov = 1'b1;
            end
        end else if (m_recov) begin
            m_recov = 1'b0;
        end else begin
            want_i = icache_read;
            want_d = dcache_read || dcache_write;
            take_d = (want_i && want_d) ? !m_last_d : want_d;
            if (take_d) begin
                m_owner  = 2;
                m_addr   = dcache_address;
                m_wdata  = dcache_wdata;
                m_wr     = dcache_write;
                m_last_d = 1'b1;
            end else if (want_i) begin
                m_owner  = 1;
                m_addr   = icache_address;
                m_wr     = 1'b0;
                m_last_d = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic clear_inputs();
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a5_line     = {(LINE_W / 8){8'hA5}};
        clear_inputs();
        icache_address = '0;
        dcache_address = '0;
        dcache_wdata   = '0;
        pmem_rdata     = '0;

        // Reset state
        rst = 1'b1;
        #1;
        model_reset();
        sample();
        check_vec("reset_state", LINE_W'(fsm_state), '0);
        advance();
        rst = 1'b0;

        // Single I-cache fill with a 4-cycle memory latency
        icache_read    = 1'b1;
        icache_address = 32'h0000_1000;
        cycle();
        for (int k = 1; k <= 4; k++) begin
            pmem_resp  = (k == 4);
            pmem_rdata = (k == 4) ? a5_line : rand_line();
            sample();
            check_bit("ifill_strobe", pmem_read, 1'b1);
            check_vec("ifill_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_1000));
            if (k == 4) begin
                check_bit("ifill_resp", icache_resp, 1'b1);
                check_vec("ifill_data", icache_rdata, a5_line);
                check_bit("ifill_no_dresp", dcache_resp, 1'b0);
            end
            advance();
        end

        // Spurious pmem_resp during RECOVER and in IDLE
        icache_read = 1'b0;
        pmem_resp   = 1'b1;
        pmem_rdata  = rand_line();
        sample();
        check_bit("recover_no_strobe", pmem_read, 1'b0);
        check_bit("recover_no_iresp", icache_resp, 1'b0);
        check_bit("recover_no_dresp", dcache_resp, 1'b0);
        advance();
        sample();
        check_bit("idle_no_iresp", icache_resp, 1'b0);
        check_bit("idle_no_dresp", dcache_resp, 1'b0);
        advance();
        check_vec("idle_stays_idle", LINE_W'(fsm_state), '0);
        check_vec("ifill_data_held", icache_rdata, a5_line);
        pmem_resp = 1'b0;

        // First conflict after reset: D writeback wins, then I fill
        do_reset();
        icache_read    = 1'b1;
        icache_address = 32'h0000_0100;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_0200;
        dcache_wdata   = rand_line();
        tmp_line       = dcache_wdata;
        cycle();
        dcache_wdata = rand_line();  // must not leak through to pmem_wdata
        pmem_resp    = 1'b1;
        pmem_rdata   = rand_line();
        sample();
        check_bit("conflict_d_write", pmem_write, 1'b1);
        check_bit("conflict_d_noread", pmem_read, 1'b0);
        check_vec("conflict_d_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0200));
        check_vec("conflict_d_wdata", pmem_wdata, tmp_line);
        check_bit("conflict_d_resp", dcache_resp, 1'b1);
        check_bit("conflict_i_waits", icache_resp, 1'b0);
        advance();
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
        cycle();  // RECOVER
        cycle();  // grant I
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        sample();
        check_bit("conflict_i_read", pmem_read, 1'b1);
        check_vec("conflict_i_addr", LINE_W'(pmem_address), LINE_W'(32'h0000_0100));
        check_bit("conflict_i_resp", icache_resp, 1'b1);
        advance();
        clear_inputs();
        cycle();

        // Both requesters held: grants alternate D, I, D, I
        do_reset();
        icache_read    = 1'b1;
        icache_address = 32'h0000_4000;
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_5000;
        for (int t = 0; t < 4; t++) begin
            cycle();  // grant
            pmem_resp  = 1'b1;
            pmem_rdata = rand_line();
            sample();
            check_bit("alt_dresp", dcache_resp, (t % 2) == 0);
            check_bit("alt_iresp", icache_resp, (t % 2) == 1);
            advance();
            pmem_resp = 1'b0;
            cycle();  // RECOVER
        end
        clear_inputs();
        cycle();

        // Reset during SERVE_D
        do_reset();
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_2040;
        cycle();
        sample();
        check_bit("rst_pre_strobe", pmem_read, 1'b1);
        advance();
        rst = 1'b1;
        #1;
        check_bit("rst_strobe_drop", pmem_read, 1'b0);
        pmem_resp = 1'b1;
        #1;
        check_bit("rst_no_dresp", dcache_resp, 1'b0);
        model_reset();
        cycle();
        rst       = 1'b0;
        pmem_resp = 1'b0;
        cycle();  // fresh grant
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        tmp_line   = pmem_rdata;
        sample();
        check_bit("rst_retry_resp", dcache_resp, 1'b1);
        check_vec("rst_retry_data", dcache_rdata, tmp_line);
        advance();
        clear_inputs();
        cycle();

        // Read and write together is a write
        dcache_read    = 1'b1;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_3000;
        dcache_wdata   = rand_line();
        tmp_line       = dcache_wdata;
        cycle();
        sample();
        check_bit("rw_is_write", pmem_write, 1'b1);
        check_bit("rw_no_read", pmem_read, 1'b0);
        check_vec("rw_wdata", pmem_wdata, tmp_line);
        advance();
        pmem_resp = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            icache_read    = ($urandom_range(0, 3) != 0);
            dcache_read    = ($urandom_range(0, 2) == 0);
            dcache_write   = ($urandom_range(0, 2) == 0);
            icache_address = $urandom;
            dcache_address = $urandom;
            dcache_wdata   = rand_line();
            pmem_resp      = ($urandom_range(0, 2) == 0);
            pmem_rdata     = rand_line();
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
            end
            cycle();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
